// File: rtl/spi_master_gen2.sv
// Parametrised SPI master: all CPOL/CPHA modes, full-duplex, start/busy/done handshake.
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first port for LSB-first shifting.
module spi_master_gen2 #(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 2,
    parameter int SS_SEL_W = 1,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [SS_SEL_W-1:0] ss_sel,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic                cpol,
    input  logic                cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    input  logic                MISO,
    output logic                MOSI,
    output logic                SCLK,
    output logic [NUM_SS-1:0]   SS_N,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rx_data
);
    localparam int EC_W = $clog2(2*DATA_W) + 1;
    localparam logic [EC_W-1:0] EDGES     = EC_W'(2*DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W - 1);
    localparam logic [SS_SEL_W:0] SS_LIMIT = (SS_SEL_W+1)'(NUM_SS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0]  div_q, div_cnt;
    logic [EC_W-1:0]   ecnt;
    logic [DATA_W-1:0] tx_sh, rx_sh, tx_load;
    logic [NUM_SS-1:0] ss_n_q;
    logic cpha_q, lsb_q, lsb_sel, sclk_q, mosi_q;
    logic accept, tick, lead, sample;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_sel = lsb_first;
`else
    assign lsb_sel = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    assign accept  = (state == IDLE) && start && ({1'b0, ss_sel} < SS_LIMIT);
    assign tick    = (div_cnt == div_q);
    // ecnt holds edges already issued, so the edge about to fire is odd when ecnt is even
    assign lead    = ~ecnt[0];
    assign sample  = lead ^ cpha_q;
    assign tx_load = lsb_sel ? bit_rev(tx_data) : tx_data;

    assign MOSI = mosi_q;
    assign SCLK = sclk_q;
    assign SS_N = ss_n_q;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = SHIFT;
            SHIFT:   if (tick && ecnt == EDGES) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            div_cnt <= '0;
            ecnt    <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= '1;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    div_q   <= clk_div;
                    cpha_q  <= cpha;
                    lsb_q   <= lsb_sel;
                    sclk_q  <= cpol;
                    div_cnt <= '0;
                    ecnt    <= '0;
                    rx_sh   <= '0;
                    ss_n_q  <= ~(NUM_SS'(1) << ss_sel);
                    // cpha=0 samples on the first edge, so the first bit must already be out
                    if (cpha) begin
                        mosi_q <= 1'b0;
                        tx_sh  <= tx_load;
                    end else begin
                        mosi_q <= tx_load[DATA_W-1];
                        tx_sh  <= tx_load << 1;
                    end
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick && state == HOLD) begin
                    ss_n_q  <= '1;
                    mosi_q  <= 1'b0;
                    done    <= 1'b1;
                    rx_data <= lsb_q ? bit_rev(rx_sh) : rx_sh;
                end else if (tick && ecnt != EDGES) begin
                    ecnt   <= ecnt + 1'b1;
                    sclk_q <= ~sclk_q;
                    if (sample) begin
                        rx_sh <= {rx_sh[DATA_W-2:0], MISO};
                    end else if (ecnt != LAST_EDGE) begin
                        mosi_q <= tx_sh[DATA_W-1];
                        tx_sh  <= tx_sh << 1;
                    end
                end
            end
        end
    end
endmodule
